// File: rtl/alu_arb_pkg.sv
// Shared definitions for the three-requester ALU arbiter.
package alu_arb_pkg;

  localparam int NREQ      = 3;
  localparam int WIDTH_DEF = 8;
  localparam int OPW_DEF   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Round-robin pointer value after a grant: one past the winner, wrapping at 3.
  function automatic logic [1:0] ptr_after(input logic [NREQ-1:0] grant);
    logic [1:0] nxt;
    nxt = 2'd0;
    if (grant[0]) nxt = 2'd1;
    if (grant[1]) nxt = 2'd2;
    if (grant[2]) nxt = 2'd0;
    return nxt;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: searches p, p+1, p+2 (mod 3), first hit wins.
module rr_pick3
  import alu_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      p,
  output logic [NREQ-1:0] grant,
  output logic            any
);

  // Priority search starting at the pointer position.
  always_comb begin
    grant = '0;
    case (p)
      2'd1: begin
        if      (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      2'd2: begin
        if      (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if      (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

  assign any = |req;

endmodule

// File: rtl/alu_share_arb3.sv
// Shares one external combinational ALU among three requesters.
// Each operation takes two cycles: IDLE grants and loads operands, EXEC holds
// them stable for the ALU and the result is captured on the way back to IDLE.
module alu_share_arb3
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*OPW-1:0]   req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       ack,
  output logic [OPW-1:0]        alu_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_y,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [NREQ-1:0]  r_ack;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;

  logic [NREQ-1:0]  w_grant;
  logic             w_any;
  logic [OPW-1:0]   w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  rr_pick3 u_pick (
    .req   (req),
    .p     (r_ptr),
    .grant (w_grant),
    .any   (w_any)
  );

  // Route the winning requester's fields toward the operand registers.
  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_op = req_op[i*OPW +: OPW];
        w_sel_a  = req_a[i*WIDTH +: WIDTH];
        w_sel_b  = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Two-state sequencer; ack marks the EXEC cycle, rsp_valid the cycle after.
  // The ack register doubles as the record of who owns the in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= 2'd0;
      r_ack       <= '0;
      r_rsp_valid <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_y         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_valid <= '0;
          if (w_any) begin
            r_state <= EXEC;
            r_ptr   <= ptr_after(w_grant);
            r_ack   <= w_grant;
            r_op    <= w_sel_op;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
          end
        end
        EXEC: begin
          r_y         <= alu_y;
          r_rsp_valid <= r_ack;
          r_ack       <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_y;
  assign alu_op    = r_op;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign busy      = (r_state == EXEC);

endmodule

// File: tb/tb_alu_share_arb3.sv
// Bench for alu_share_arb3: the bench plays the external ALU, drives request
// scenarios and checks grants/results against a queue-based scoreboard.
module tb_alu_share_arb3;

  localparam int W = 8;
  localparam int O = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [2:0]     req;
  logic [3*O-1:0] req_op;
  logic [3*W-1:0] req_a;
  logic [3*W-1:0] req_b;
  logic [2:0]     ack;
  logic [O-1:0]   alu_op;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_y;
  logic [2:0]     rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           busy;

  logic [O-1:0] op_f [3];
  logic [W-1:0] a_f  [3];
  logic [W-1:0] b_f  [3];

  assign req_op = {op_f[2], op_f[1], op_f[0]};
  assign req_a  = {a_f[2], a_f[1], a_f[0]};
  assign req_b  = {b_f[2], b_f[1], b_f[0]};

  function automatic logic [W-1:0] alu_ref(input logic [O-1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a | b;
      3'd3:    return a & b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_y = alu_ref(alu_op, alu_a, alu_b);

  alu_share_arb3 #(.WIDTH(W), .OPW(O)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .ack       (ack),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_ack_cyc = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } rsp_t;

  int   exp_ack [$];
  rsp_t exp_rsp [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: grant order, result routing/data and result latency.
  always @(negedge clk) begin
    int   e;
    rsp_t r;
    if (!rst) begin
      check_eq("busy_vs_ack", 32'(busy), 32'(ack != 3'b000));
      if (ack != 3'b000) begin
        if (exp_ack.size() == 0) check_eq("unexpected_ack", 32'(ack), 32'd0);
        else begin
          e = exp_ack.pop_front();
          check_eq("ack_order", 32'(ack), 32'(1) << e);
        end
        last_ack_cyc = cyc;
      end
      if (rsp_valid != 3'b000) begin
        if (exp_rsp.size() == 0) check_eq("unexpected_rsp", 32'(rsp_valid), 32'd0);
        else begin
          r = exp_rsp.pop_front();
          check_eq("rsp_valid", 32'(rsp_valid), 32'(1) << r.idx);
          check_eq("rsp_data", 32'(rsp_data), 32'(r.data));
          check_eq("rsp_latency", 32'(cyc), 32'(last_ack_cyc + 1));
        end
      end
    end
  end

  task automatic set_fields(input int i, input logic [O-1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    op_f[i] = op;
    a_f[i]  = a;
    b_f[i]  = b;
  endtask

  task automatic expect_op(input int i, input bit with_rsp);
    rsp_t r;
    exp_ack.push_back(i);
    if (with_rsp) begin
      r.idx  = i;
      r.data = alu_ref(op_f[i], a_f[i], b_f[i]);
      exp_rsp.push_back(r);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ack"},   32'(ack), 32'd0);
    check_eq({tag, "_rspv"},  32'(rsp_valid), 32'd0);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_op"},    32'(alu_op), 32'd0);
    check_eq({tag, "_a"},     32'(alu_a), 32'd0);
    check_eq({tag, "_b"},     32'(alu_b), 32'd0);
    check_eq({tag, "_rdata"}, 32'(rsp_data), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    req = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    #1 rst = 1'b0;
  endtask

  // Waits (bounded) for ack[idx]; returns the cycle and how many negedges it took.
  task automatic wait_ack(input int idx, input int budget, output int at_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[idx] && n < budget);
    check_eq($sformatf("ack%0d_seen", idx), 32'(ack[idx]), 32'd1);
    at_cyc = cyc;
  endtask

  task automatic drain(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int c, prev, n;
    rst = 1'b1;
    req = 3'b000;
    for (int i = 0; i < 3; i++) set_fields(i, 3'd0, 8'h00, 8'h00);

    // Single request, OR of complementary nibbles.
    apply_reset();
    set_fields(0, 3'd2, 8'h0F, 8'hF0);
    expect_op(0, 1'b1);
    req = 3'b001;
    @(negedge clk);
    check_eq("single_ack", 32'(ack), 32'b001);
    check_eq("single_alu_a", 32'(alu_a), 32'h0F);
    req = 3'b000;
    @(negedge clk);
    check_eq("single_rspv", 32'(rsp_valid), 32'b001);
    check_eq("single_rdata", 32'(rsp_data), 32'hFF);
    check_eq("single_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("single_rspv_pulse", 32'(rsp_valid), 32'd0);
    check_eq("single_rdata_hold", 32'(rsp_data), 32'hFF);
    check_eq("single_alu_hold", 32'(alu_b), 32'hF0);

    // All three requesting: 0,1,2,0 then 1 shows the pointer is back at 1.
    apply_reset();
    set_fields(0, 3'd0, 8'h10, 8'h05);
    set_fields(1, 3'd1, 8'h20, 8'h03);
    set_fields(2, 3'd4, 8'hAA, 8'hFF);
    expect_op(0, 1'b1); expect_op(1, 1'b1); expect_op(2, 1'b1);
    expect_op(0, 1'b1); expect_op(1, 1'b1);
    req = 3'b111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(k % 3, 10, c, n);
      if (k > 0) check_eq("all_spacing", 32'(c - prev), 32'd2);
      prev = c;
    end
    req = 3'b000;
    drain(3);

    // Pointer skip: after granting 0 (p=1), req=101 grants 2, then 0.
    apply_reset();
    set_fields(0, 3'd3, 8'h3C, 8'hF5);
    set_fields(2, 3'd1, 8'h50, 8'h08);
    expect_op(0, 1'b1);
    req = 3'b001;
    wait_ack(0, 10, c, n);
    req = 3'b000;
    drain(2);
    expect_op(2, 1'b1);
    expect_op(0, 1'b1);
    req = 3'b101;
    wait_ack(2, 10, c, n);
    req[2] = 1'b0;
    wait_ack(0, 10, c, n);
    req = 3'b000;
    drain(3);

    // Reset in EXEC aborts the operation; first edge after release grants 1.
    apply_reset();
    set_fields(0, 3'd1, 8'h33, 8'h11);
    set_fields(1, 3'd4, 8'h5A, 8'h0F);
    expect_op(0, 1'b0);
    req = 3'b001;
    wait_ack(0, 10, c, n);
    req = 3'b000;
    #1 rst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    #1 rst = 1'b0;
    expect_op(1, 1'b1);
    req = 3'b010;
    wait_ack(1, 10, c, n);
    check_eq("abort_first_edge", 32'(n), 32'd1);
    req = 3'b000;
    drain(4);

    // Withdrawal: requester 2 drops while 0 executes and is never served.
    apply_reset();
    set_fields(0, 3'd0, 8'hF0, 8'h20);
    set_fields(2, 3'd2, 8'h01, 8'h02);
    expect_op(0, 1'b1);
    req = 3'b101;
    wait_ack(0, 10, c, n);
    req = 3'b000;
    @(negedge clk);
    check_eq("wd_rspv", 32'(rsp_valid), 32'b001);
    check_eq("wd_busy", 32'(busy), 32'd0);
    drain(4);
    check_eq("wd_no_ack2", 32'(ack), 32'd0);

    // Back-to-back: requester 1 held alone is regranted every 2 cycles.
    apply_reset();
    set_fields(1, 3'd1, 8'h07, 8'h09);
    expect_op(1, 1'b1); expect_op(1, 1'b1); expect_op(1, 1'b1);
    req = 3'b010;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_ack(1, 10, c, n);
      if (k > 0) check_eq("b2b_spacing", 32'(c - prev), 32'd2);
      prev = c;
    end
    req = 3'b000;
    drain(4);

    check_eq("scoreboard_empty", 32'(exp_ack.size() + exp_rsp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_share_arb3.md
ALU_SHARE_ARB3 -- requirements
Module: alu_share_arb3

Interface
REQ-001 Parameters SHALL be:
  - WIDTH, 8, operand/result width.
  - OPW, 3, ALU opcode width.
REQ-002 Ports SHALL be:
  - clk  in  1  single clock; all state updates on rising edge.
  - rst  in  1  reset; synchronous, active-high.
  - req  in  3  request per requester i (0..2), level, held until ack[i].
  - req_op  in  3*OPW  opcode of requester i at bits [i*OPW +: OPW].
  - req_a  in  3*WIDTH  operand A of requester i at bits [i*WIDTH +: WIDTH].
  - req_b  in  3*WIDTH  operand B of requester i, same packing.
  - ack  out  3  one-hot grant acknowledge, one-cycle pulse.
  - alu_op  out  OPW  registered opcode to the shared ALU.
  - alu_a  out  WIDTH  registered operand A to the ALU.
  - alu_b  out  WIDTH  registered operand B to the ALU.
  - alu_y  in  WIDTH  combinational ALU result.
  - rsp_valid  out  3  one-hot result strobe, one-cycle pulse.
  - rsp_data  out  WIDTH  registered result, valid with rsp_valid.
  - busy  out  1  high while an operation is in flight (state EXEC).

Function
REQ-003 Block SHALL share one combinational ALU among 3 requesters, one operation at a time.
REQ-004 FSM SHALL have exactly two states:
  - IDLE: waiting for requests.
  - EXEC: ALU inputs held stable for one cycle.
REQ-005 IDLE: if req != 0 at an edge, SHALL grant one requester by round-robin, load alu_op/alu_a/alu_b from that requester's fields, and enter EXEC.
REQ-006 IDLE with req == 0 SHALL remain in IDLE; alu_op/alu_a/alu_b SHALL hold their last values.
REQ-007 ack[g] SHALL be 1 during exactly the EXEC cycle of granted requester g; all other ack bits 0.
REQ-008 EXEC: at the next edge, SHALL capture alu_y into rsp_data, pulse rsp_valid[g] for one cycle, and return to IDLE.
REQ-009 Latency SHALL be fixed:
  - req sampled at edge N;
  - ack during cycle N..N+1;
  - rsp_valid during cycle N+1..N+2.
  - Maximum throughput is one operation per 2 cycles.
REQ-010 Round-robin SHALL use a 2-bit pointer p (values 0..2):
  - Search order is p, p+1, p+2 mod 3; first asserted req wins.
  - On grant, p SHALL become (winner+1) mod 3.
REQ-011 req SHALL be ignored in EXEC; a req deasserted before being granted SHALL be dropped without side effect.
REQ-012 A requester keeping req high in the cycle it receives rsp_valid SHALL be eligible for a new grant at that edge, subject to REQ-010.
REQ-013 With all three requesting continuously from reset, grants SHALL follow the sequence 0,1,2,0,...
REQ-014 rsp_data SHALL hold its value between strobes.
REQ-015 busy SHALL equal (state == EXEC).
REQ-016 Result width SHALL equal WIDTH; no carry or flag handling in this block.

Reset
REQ-017 While rst is 1 at an edge:
  - state SHALL become IDLE and p SHALL become 0;
  - ack, rsp_valid, busy SHALL be 0;
  - alu_op, alu_a, alu_b, rsp_data SHALL be all-zero.
REQ-018 rst asserted during EXEC SHALL abort the operation; no rsp_valid SHALL be issued for it.
REQ-019 The first edge after rst deasserts SHALL be a normal IDLE evaluation.

Structure
REQ-020 Package alu_arb_pkg SHALL hold:
  - NREQ = 3;
  - the state type {IDLE, EXEC};
  - default WIDTH/OPW constants.
REQ-021 Round-robin selection SHALL be a combinational sub-module rr_pick3:
  - inputs: req[2:0], p[1:0];
  - outputs: one-hot grant[2:0], any.
REQ-022 The shared ALU SHALL remain external; this block contains no arithmetic.

Verification
REQ-023 Single request: rst then req=001, op=2, a=8'h0F, b=8'hF0, ALU model OR:
  - ack=001 one cycle later;
  - rsp_valid=001 with rsp_data=8'hFF two cycles after request.
REQ-024 All request: req=111 held → grant order 0,1,2,0; an ack pulse every 2 cycles; p returns to 1 after the 4th grant.
REQ-025 Pointer skip: p=1 and req=101 → requester 2 granted, then p=0.
REQ-026 Reset mid-operation: rst pulsed during EXEC → no rsp_valid; all outputs 0; next req=010 → grant 1 (p=0 search order, only 1 asserted).
REQ-027 Request withdrawal:
  - req[2] drops while requester 0 is in EXEC → requester 2 never acked;
  - busy low after rsp_valid=001.
REQ-028 Back-to-back: requester 1 keeps req high through rsp_valid with others idle → regranted at that edge; rsp_valid=010 every 2 cycles.
